// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
package pwm_pkg;

  // Default counter width used by both the generator and the capture block.
  localparam int unsigned PWM_WIDTH = 16;

  // Capture FSM: IDLE waits for the first rise, HIGH/LOW track the current phase.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

  // Number of bits needed to hold values 0..maxval (at least 1).
  function automatic int unsigned cnt_bits(input int unsigned maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer followed by an edge register. The synchronized
// level and the rise/fall pulses are registered together so they line up.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   lvl_q;
  logic                   rise_q;
  logic                   fall_q;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  // Register the level and its edge pulses in the same stage so s, rise and fall stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      lvl_q  <= sync_out;
      rise_q <= sync_out & ~lvl_q;
      fall_q <= ~sync_out & lvl_q;
    end
  end

  assign s    = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an external PWM line in clk
// cycles, saturating counters, and reports a static line via a timeout.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = PWM_WIDTH,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             meas_valid,
  output logic             overflow,
  output logic             signal_lost,
  output logic             static_level
);

  // The idle counter is sized from TIMEOUT alone so a narrow WIDTH never limits it.
  localparam int unsigned        IDLE_W   = cnt_bits(TIMEOUT);
  localparam logic [WIDTH-1:0]   CNT_MAX  = '1;
  localparam logic [IDLE_W-1:0]  IDLE_LIM = IDLE_W'(TIMEOUT);

  logic s;
  logic rise;
  logic fall;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pwm_in),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  pwm_state_e        state_q;
  logic [WIDTH-1:0]  per_q;
  logic [WIDTH-1:0]  hi_q;
  logic [IDLE_W-1:0] idle_q;
  logic              sat_q;

  logic [WIDTH-1:0]  period_q;
  logic [WIDTH-1:0]  duty_q;
  logic              valid_q;
  logic              ovf_q;
  logic              lost_q;
  logic              static_q;

  logic [WIDTH-1:0]  per_inc;
  logic [WIDTH-1:0]  hi_inc;
  logic [IDLE_W-1:0] idle_inc;
  logic              sat_inc;
  logic              timeout;

  // Saturating increments and the timeout condition.
  always_comb begin
    per_inc  = (per_q == CNT_MAX) ? CNT_MAX : per_q + 1'b1;
    hi_inc   = (hi_q  == CNT_MAX) ? CNT_MAX : hi_q  + 1'b1;
    // hi never exceeds per, so watching per alone catches any saturation.
    sat_inc  = sat_q | (per_inc == CNT_MAX);
    idle_inc = idle_q + 1'b1;
    timeout  = (idle_q == IDLE_LIM);
  end

  // Measurement FSM with its counters and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      idle_q   <= '0;
      sat_q    <= 1'b0;
      period_q <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      lost_q   <= 1'b0;
      static_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_q <= ST_HIGH;
            per_q   <= {{(WIDTH-1){1'b0}}, 1'b1};
            hi_q    <= {{(WIDTH-1){1'b0}}, 1'b1};
            idle_q  <= '0;
            sat_q   <= 1'b0;
          end
        end
        ST_HIGH, ST_LOW: begin
          // Edge checks come before the timeout so a rise on the timeout cycle still reports.
          if (rise) begin
            period_q <= per_q;
            duty_q   <= hi_q;
            ovf_q    <= sat_q;
            valid_q  <= 1'b1;
            lost_q   <= 1'b0;
            state_q  <= ST_HIGH;
            per_q    <= {{(WIDTH-1){1'b0}}, 1'b1};
            hi_q     <= {{(WIDTH-1){1'b0}}, 1'b1};
            idle_q   <= '0;
            sat_q    <= 1'b0;
          end else if (fall) begin
            state_q <= ST_LOW;
            per_q   <= per_inc;
            sat_q   <= sat_inc;
            idle_q  <= '0;
          end else if (timeout) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            duty_q   <= '0;
            ovf_q    <= 1'b0;
            lost_q   <= 1'b1;
            static_q <= s;
            valid_q  <= 1'b1;
            per_q    <= '0;
            hi_q     <= '0;
            idle_q   <= '0;
            sat_q    <= 1'b0;
          end else begin
            per_q  <= per_inc;
            sat_q  <= sat_inc;
            idle_q <= idle_inc;
            if (state_q == ST_HIGH) begin
              hi_q <= hi_inc;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign period       = period_q;
  assign duty_cycle   = duty_q;
  assign meas_valid   = valid_q;
  assign overflow     = ovf_q;
  assign signal_lost  = lost_q;
  assign static_level = static_q;

endmodule

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int unsigned W0   = 16;
  localparam int unsigned W1   = 4;
  localparam int unsigned T0   = 40;
  localparam int unsigned T1   = 60;
  localparam int unsigned SYNC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pwm   = 1'b0;

  logic [W0-1:0] per0, duty0;
  logic          mv0, ov0, lost0, st0;
  logic [W1-1:0] per1, duty1;
  logic          mv1, ov1, lost1, st1;

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(W0), .SYNC_STAGES(SYNC), .TIMEOUT(T0)) u0 (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm), .period(per0), .duty_cycle(duty0),
    .meas_valid(mv0), .overflow(ov0), .signal_lost(lost0), .static_level(st0));

  pwm_capture #(.WIDTH(W1), .SYNC_STAGES(SYNC), .TIMEOUT(T1)) u1 (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm), .period(per1), .duty_cycle(duty1),
    .meas_valid(mv1), .overflow(ov1), .signal_lost(lost1), .static_level(st1));

  typedef struct {
    int per; int duty; int ovf; int lost; int stat; int cyc;
  } rep_t;

  rep_t q0[$];
  rep_t q1[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- reference model (operates on input change times) ----------------
  int   maxv [2] = '{65535, 15};
  int   tmo  [2] = '{40, 60};
  int   act  [2] = '{0, 0};
  int   lrise[2] = '{0, 0};
  int   lfall[2] = '{0, 0};
  int   ledge[2] = '{0, 0};
  logic prev_v   = 1'b0;

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic push(input int i, input rep_t r);
    if (i == 0) q0.push_back(r); else q1.push_back(r);
  endtask

  // Input level v holds for drive slot n (captured by the DUT on the following edge).
  task automatic model(input logic v, input int n);
    rep_t r;
    for (int i = 0; i < 2; i++) begin
      if (v !== prev_v) begin
        if (v) begin
          if (act[i] != 0) begin
            r.per  = mn(n - lrise[i], maxv[i]);
            r.duty = mn(lfall[i] - lrise[i], maxv[i]);
            r.ovf  = ((n - lrise[i]) >= maxv[i]) ? 1 : 0;
            r.lost = 0; r.stat = 0;
            r.cyc  = n + int'(SYNC) + 2;
            push(i, r);
          end
          act[i]   = 1;
          lrise[i] = n;
        end else begin
          lfall[i] = n;
        end
        ledge[i] = n;
      end else if (act[i] != 0 && (n - ledge[i]) == tmo[i] + 1) begin
        r.per = 0; r.duty = 0; r.ovf = 0; r.lost = 1; r.stat = int'(v);
        r.cyc = n + int'(SYNC) + 2;
        push(i, r);
        act[i] = 0;
      end
    end
  endtask

  task automatic step(input logic v);
    @(posedge clk); #1;
    pwm = v;
    if (rst_n) model(v, cyc);
    prev_v = v;
  endtask

  // ---------------- output monitor ----------------
  task automatic mon(input int i, input logic mv, input logic [31:0] p, input logic [31:0] d,
                     input logic o, input logic l, input logic s);
    rep_t e;
    int   sz;
    sz = (i == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      chk($sformatf("u%0d_spurious_valid", i), 32'(mv), 0);
      return;
    end
    if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
    chk($sformatf("u%0d_period", i), p, e.per);
    chk($sformatf("u%0d_duty", i), d, e.duty);
    chk($sformatf("u%0d_overflow", i), 32'(o), e.ovf);
    chk($sformatf("u%0d_signal_lost", i), 32'(l), e.lost);
    if (e.lost != 0) begin
      chk($sformatf("u%0d_static_level", i), 32'(s), e.stat);
      chk_rng($sformatf("u%0d_timeout_cycle", i), cyc, e.cyc - 2, e.cyc + 2);
    end else begin
      chk($sformatf("u%0d_report_cycle", i), cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mv0 !== 1'b0) mon(0, mv0, 32'(per0), 32'(duty0), ov0, lost0, st0);
      if (mv1 !== 1'b0) mon(1, mv1, 32'(per1), 32'(duty1), ov1, lost1, st1);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_u0_period"}, 32'(per0), 0);
    chk({tag, "_u0_duty"}, 32'(duty0), 0);
    chk({tag, "_u0_valid"}, 32'(mv0), 0);
    chk({tag, "_u0_overflow"}, 32'(ov0), 0);
    chk({tag, "_u0_lost"}, 32'(lost0), 0);
    chk({tag, "_u0_static"}, 32'(st0), 0);
    chk({tag, "_u1_period"}, 32'(per1), 0);
    chk({tag, "_u1_duty"}, 32'(duty1), 0);
    chk({tag, "_u1_valid"}, 32'(mv1), 0);
    chk({tag, "_u1_overflow"}, 32'(ov1), 0);
    chk({tag, "_u1_lost"}, 32'(lost1), 0);
    chk({tag, "_u1_static"}, 32'(st1), 0);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) act[i] = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int hi; int lo; int reps; int tail; int tlen;
    int p0; int d0; int o0; int p1; int d1; int o1; int lost; int stat;
  } vec_t;

  vec_t tab[7];

  initial begin
    tab[0] = '{hi:5,  lo:5, reps:4, tail:1, tlen:8,  p0:10, d0:5,  o0:0, p1:10, d1:5,  o1:0, lost:0, stat:0};
    tab[1] = '{hi:4,  lo:6, reps:2, tail:0, tlen:90, p0:0,  d0:0,  o0:0, p1:0,  d1:0,  o1:0, lost:1, stat:0};
    tab[2] = '{hi:3,  lo:7, reps:2, tail:1, tlen:90, p0:0,  d0:0,  o0:0, p1:0,  d1:0,  o1:0, lost:1, stat:1};
    tab[3] = '{hi:3,  lo:7, reps:3, tail:1, tlen:8,  p0:10, d0:3,  o0:0, p1:10, d1:3,  o1:0, lost:0, stat:0};
    tab[4] = '{hi:20, lo:5, reps:2, tail:1, tlen:8,  p0:25, d0:20, o0:0, p1:15, d1:15, o1:1, lost:0, stat:0};
    tab[5] = '{hi:5,  lo:5, reps:3, tail:1, tlen:8,  p0:10, d0:5,  o0:0, p1:10, d1:5,  o1:0, lost:0, stat:0};
    tab[6] = '{hi:1,  lo:1, reps:6, tail:1, tlen:8,  p0:2,  d0:1,  o0:0, p1:2,  d1:1,  o1:0, lost:0, stat:0};

    // Reset held while the line toggles: nothing may come out.
    for (int k = 0; k < 12; k++) begin
      step(k[1]);
      @(negedge clk);
      chk("reset_u0_valid", 32'(mv0), 0);
      chk("reset_u1_valid", 32'(mv1), 0);
    end
    repeat (6) step(1'b0);
    chk_zero("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (4) step(1'b0);

    // Table-driven waveforms with final output state compared against table constants.
    for (int t = 0; t < 7; t++) begin
      for (int r = 0; r < tab[t].reps; r++) begin
        repeat (tab[t].hi) step(1'b1);
        repeat (tab[t].lo) step(1'b0);
      end
      repeat (tab[t].tlen) step(tab[t].tail[0]);
      @(negedge clk);
      chk($sformatf("tab%0d_u0_period", t), 32'(per0), tab[t].p0);
      chk($sformatf("tab%0d_u0_duty", t), 32'(duty0), tab[t].d0);
      chk($sformatf("tab%0d_u0_overflow", t), 32'(ov0), tab[t].o0);
      chk($sformatf("tab%0d_u0_lost", t), 32'(lost0), tab[t].lost);
      chk($sformatf("tab%0d_u1_period", t), 32'(per1), tab[t].p1);
      chk($sformatf("tab%0d_u1_duty", t), 32'(duty1), tab[t].d1);
      chk($sformatf("tab%0d_u1_overflow", t), 32'(ov1), tab[t].o1);
      chk($sformatf("tab%0d_u1_lost", t), 32'(lost1), tab[t].lost);
      if (tab[t].lost != 0) begin
        chk($sformatf("tab%0d_u0_static", t), 32'(st0), tab[t].stat);
        chk($sformatf("tab%0d_u1_static", t), 32'(st1), tab[t].stat);
      end
    end

    // Reset asserted mid-HIGH: outputs clear at once, then two rises are needed for a report.
    repeat (5) step(1'b0);
    repeat (5) step(1'b1);
    repeat (5) step(1'b0);
    repeat (3) step(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midhigh_reset");
    model_reset();
    repeat (6) step(1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) step(1'b0);
    repeat (4) step(1'b1);
    repeat (4) step(1'b0);
    @(negedge clk);
    chk("post_reset_first_rise_u0_period", 32'(per0), 0);
    chk("post_reset_first_rise_u1_period", 32'(per1), 0);
    repeat (8) step(1'b1);
    @(negedge clk);
    chk("post_reset_second_rise_u0_period", 32'(per0), 8);
    chk("post_reset_second_rise_u0_duty", 32'(duty0), 4);
    chk("post_reset_second_rise_u1_period", 32'(per1), 8);

    // Randomized segments: short gaps stay well below both timeouts, long ones well above.
    begin
      logic lvl;
      int   len;
      lvl = 1'b1;
      for (int seg = 0; seg < 220; seg++) begin
        lvl = ~lvl;
        if ($urandom_range(0, 11) == 0) len = int'($urandom_range(75, 90));
        else                            len = int'($urandom_range(1, 25));
        repeat (len) step(lvl);
      end
    end

    // Let everything drain: a long low stretch ends with any pending timeout reported.
    repeat (100) step(1'b0);
    @(negedge clk);
    chk("u0_pending_reports", q0.size(), 0);
    chk("u1_pending_reports", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
